// File: rtl/smol_pkg.sv
// -----------------------------------------------------------------------------
// smol_pkg
// Shared constants and types for the smol fetch path.
//   SMOL_ADDR_WIDTH : default word-address width of the instruction ROM
//   SMOL_DATA_WIDTH : default instruction width
//   instr_t         : one instruction word
//   pc_t            : one byte address (word address plus two low zero bits)
//   fetch_entry_t   : an instruction tagged with the PC it was fetched from
// -----------------------------------------------------------------------------
package smol_pkg;

   localparam int SMOL_ADDR_WIDTH = 10;
   localparam int SMOL_DATA_WIDTH = 32;

   typedef logic [SMOL_DATA_WIDTH-1:0] instr_t;
   typedef logic [SMOL_ADDR_WIDTH+1:0] pc_t;

   typedef struct packed {
      pc_t    pc;
      instr_t instr;
   } fetch_entry_t;

endpackage

// File: rtl/smol_fetch_fifo.sv
// -----------------------------------------------------------------------------
// smol_fetch_fifo
// Small synchronous FIFO holding fetched {pc, instruction} entries.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   i_push     : write i_data at the tail
//   i_pop      : drop the head entry
//   i_flush    : discard all entries; wins over push and pop
//   i_data     : entry to write
//   o_count    : number of valid entries (0..DEPTH)
//   o_head     : entry at the head (all zeros out of reset)
// -----------------------------------------------------------------------------
module smol_fetch_fifo #(
   parameter int WIDTH = 44,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  logic                       i_flush,
   input  logic [WIDTH-1:0]           i_data,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic [WIDTH-1:0]           o_head
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wrPtr;
   logic [PW-1:0]    r_rdPtr;
   logic [PW:0]      r_count;

   // Storage is cleared on reset so the head reads as zero before the first push.
   // Flushing only rewinds the pointers; stale storage is hidden behind count=0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wrPtr] <= i_data;
            r_wrPtr        <= r_wrPtr + 1'b1;
         end
         if (i_pop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_count = r_count;
   assign o_head  = r_mem[r_rdPtr];

endmodule

// File: rtl/smol_fetch_unit.sv
// -----------------------------------------------------------------------------
// smol_fetch_unit
// Instruction-fetch initiator: drives byte addresses into the instruction ROM,
// buffers returned words in a prefetch FIFO and hands them to decode tagged
// with their PC. Redirects flush the buffer and drop any read still in flight.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   imem_addr         : byte address to the ROM (current fetch PC, word aligned)
//   imem_instruction  : ROM read data (same cycle or one cycle later, SYNC_READ)
//   redirect_valid/pc : one-cycle pulse restarting fetch at redirect_pc
//   instr_valid/ready : handshake towards decode
//   instr_data/pc     : head instruction and its byte PC
// Optional build macro SMOL_FETCH_PERF_EN adds:
//   perf_fetched      : count of entries pushed into the FIFO
//   perf_flushed      : count of entries discarded by redirects
// -----------------------------------------------------------------------------
module smol_fetch_unit
   import smol_pkg::*;
#(
   parameter int          ADDR_WIDTH = SMOL_ADDR_WIDTH,
   parameter int          DATA_WIDTH = SMOL_DATA_WIDTH,
   parameter int unsigned RESET_PC   = 0,
   parameter int          SYNC_READ  = 1,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   output logic [ADDR_WIDTH+1:0]   imem_addr,
   input  logic [DATA_WIDTH-1:0]   imem_instruction,
   input  logic                    redirect_valid,
   input  logic [ADDR_WIDTH+1:0]   redirect_pc,
   output logic                    instr_valid,
   input  logic                    instr_ready,
   output logic [DATA_WIDTH-1:0]   instr_data,
   output logic [ADDR_WIDTH+1:0]   instr_pc
`ifdef SMOL_FETCH_PERF_EN
   ,
   output logic [31:0]             perf_fetched,
   output logic [31:0]             perf_flushed
`endif
);

   localparam int PC_W  = ADDR_WIDTH + 2;
   localparam int CW    = $clog2(FIFO_DEPTH) + 1;
   localparam int ENT_W = PC_W + DATA_WIDTH;

   localparam logic [PC_W-1:0] PC_STEP       = PC_W'(4);
   localparam logic [PC_W-1:0] PC_ALIGN_MASK = ~PC_W'(3);
   localparam logic [PC_W-1:0] RESET_PC_AL   = PC_W'(RESET_PC) & PC_ALIGN_MASK;

   logic [PC_W-1:0]  r_fetchPc;
   logic [PC_W-1:0]  r_pendingPc;
   logic             r_inflight;

   logic [CW-1:0]    w_count;
   logic [CW:0]      w_occupancy;
   logic             w_pop;
   logic             w_issue;
   logic             w_push;
   logic [PC_W-1:0]  w_pushPc;
   logic [PC_W-1:0]  w_redirectPc;
   logic [ENT_W-1:0] w_pushEntry;
   logic [ENT_W-1:0] w_headEntry;

   assign w_pop        = instr_valid && instr_ready;
   assign w_redirectPc = redirect_pc & PC_ALIGN_MASK;

   // Occupancy counts entries buffered plus the read that will land next
   // cycle, minus the one leaving now; a fetch is only issued when its word is
   // guaranteed a FIFO slot, so the FIFO can never overflow.
   assign w_occupancy = {1'b0, w_count} + (CW+1)'(r_inflight) - (CW+1)'(w_pop);
   assign w_issue     = !redirect_valid && (w_occupancy < (CW+1)'(FIFO_DEPTH));

   // With an async ROM the word for the current PC is already on the bus, so
   // it is pushed as it is issued. With a sync ROM it arrives one cycle later
   // and is tagged with the PC remembered at issue time; a redirect in that
   // cycle drops it.
   always_comb begin
      w_push   = 1'b0;
      w_pushPc = r_fetchPc;
      if (SYNC_READ != 0) begin
         w_push   = r_inflight && !redirect_valid;
         w_pushPc = r_pendingPc;
      end else begin
         w_push   = w_issue;
         w_pushPc = r_fetchPc;
      end
   end

   // Fetch PC and in-flight tracking; a redirect overrides any issue.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fetchPc   <= RESET_PC_AL;
         r_pendingPc <= '0;
         r_inflight  <= 1'b0;
      end else if (redirect_valid) begin
         r_fetchPc  <= w_redirectPc;
         r_inflight <= 1'b0;
      end else begin
         if (w_issue) begin
            r_fetchPc   <= r_fetchPc + PC_STEP;
            r_pendingPc <= r_fetchPc;
         end
         r_inflight <= (SYNC_READ != 0) && w_issue;
      end
   end

   assign w_pushEntry = {w_pushPc, imem_instruction};

   smol_fetch_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (redirect_valid),
      .i_data  (w_pushEntry),
      .o_count (w_count),
      .o_head  (w_headEntry)
   );

   assign imem_addr   = r_fetchPc;
   assign instr_valid = (w_count != '0);
   assign instr_pc    = w_headEntry[ENT_W-1:DATA_WIDTH];
   assign instr_data  = w_headEntry[DATA_WIDTH-1:0];

`ifdef SMOL_FETCH_PERF_EN
   logic [31:0] r_perfFetched;
   logic [31:0] r_perfFlushed;

   // Discarded entries on a redirect are the buffered ones not popped this
   // cycle, plus a sync-ROM word that was about to land.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_perfFetched <= '0;
         r_perfFlushed <= '0;
      end else begin
         if (w_push) begin
            r_perfFetched <= r_perfFetched + 32'd1;
         end
         if (redirect_valid) begin
            r_perfFlushed <= r_perfFlushed + 32'(w_count) - 32'(w_pop) + 32'(r_inflight);
         end
      end
   end

   assign perf_fetched = r_perfFetched;
   assign perf_flushed = r_perfFlushed;
`endif

endmodule
